// File: rtl/xdma_grant_arbiter_mc.sv
// Multi-channel xDMA grant arbiter: per-channel request FSMs sharing one registered
// grant port under round-robin arbitration, with cancel-before-issue and finish timeout.
module xdma_grant_arbiter_mc #(
    parameter int unsigned NumChan       = 4,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned IdWidth       = 8,
    parameter logic [63:0] ClusterSize   = 64'h4_0000,
    parameter logic [63:0] MainMemBase   = 64'h8000_0000,
    parameter logic [63:0] MainMemEnd    = 64'h1_0000_0000,
    parameter logic [63:0] GrantOffset   = 64'h100,
    parameter int unsigned TimeoutCycles = 4096,
    localparam int unsigned ChanW        = (NumChan > 1) ? $clog2(NumChan) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumChan-1:0]             req_rdy_i,
    input  logic [NumChan-1:0]             req_type_i,
    input  logic [NumChan*IdWidth-1:0]     req_id_i,
    input  logic [NumChan*AddrWidth-1:0]   req_src_i,
    output logic                           grant_valid_o,
    input  logic                           grant_ready_i,
    output logic [ChanW-1:0]               grant_chan_o,
    output logic [IdWidth-1:0]             grant_id_o,
    output logic [AddrWidth-1:0]           grant_from_o,
    output logic [AddrWidth-1:0]           grant_remote_addr_o,
    output logic [NumChan-1:0]             busy_o,
    output logic [NumChan-1:0]             timeout_o,
    input  logic                           timeout_clr_i
);

    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0]      TMax    = CntW'(TimeoutCycles);
    localparam logic [AddrWidth-1:0] ClustA  = ClusterSize[AddrWidth-1:0];
    localparam logic [AddrWidth-1:0] MaskA   = ~(ClustA - AddrWidth'(1));
    localparam logic [AddrWidth-1:0] MemEndA = MainMemEnd[AddrWidth-1:0];
    localparam logic [AddrWidth-1:0] OffA    = GrantOffset[AddrWidth-1:0];

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ISSUED  = 2'd2,
        ST_WAIT    = 2'd3
    } chan_state_e;

    // Grant slot sits GrantOffset below the end of the region that owns src.
    function automatic logic [AddrWidth-1:0] grant_slot_addr(input logic [AddrWidth-1:0] src);
        logic [AddrWidth-1:0] res;
        if (64'(src) >= MainMemBase) begin
            res = MemEndA - OffA;
        end else begin
            res = (src & MaskA) + ClustA - OffA;
        end
        return res;
    endfunction

    chan_state_e          state_r [NumChan];
    logic [CntW-1:0]      cnt_r   [NumChan];
    logic [NumChan-1:0]   busy_r;
    logic [NumChan-1:0]   timeout_r;
    logic [ChanW-1:0]     rr_ptr_r;

    logic                 grant_valid_r;
    logic [ChanW-1:0]     grant_chan_r;
    logic [IdWidth-1:0]   grant_id_r;
    logic [AddrWidth-1:0] grant_from_r;
    logic [AddrWidth-1:0] grant_raddr_r;

    logic [NumChan-1:0]   act_s;
    logic                 free_s;
    logic                 hs_s;
    logic                 load_s;
    logic                 sel_found_s;
    logic [ChanW-1:0]     sel_idx_s;
    logic [IdWidth-1:0]   sel_id_s;
    logic [AddrWidth-1:0] sel_src_s;

    assign act_s  = req_rdy_i & req_type_i;
    assign free_s = !grant_valid_r || grant_ready_i;
    assign hs_s   = grant_valid_r && grant_ready_i;
    assign load_s = free_s && sel_found_s;

    // Round-robin pick: first pending, still-active channel at or after rr_ptr_r.
    always_comb begin
        int   idx_v;
        logic hit_v;
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        sel_id_s    = '0;
        sel_src_s   = '0;
        idx_v       = 0;
        hit_v       = 1'b0;
        for (int i = 0; i < int'(NumChan); i++) begin
            idx_v       = (int'(rr_ptr_r) + i) % int'(NumChan);
            hit_v       = !sel_found_s && (state_r[idx_v] == ST_PENDING) && act_s[idx_v];
            sel_idx_s   = hit_v ? ChanW'(idx_v) : sel_idx_s;
            sel_id_s    = hit_v ? req_id_i[idx_v*IdWidth +: IdWidth] : sel_id_s;
            sel_src_s   = hit_v ? req_src_i[idx_v*AddrWidth +: AddrWidth] : sel_src_s;
            sel_found_s = sel_found_s | hit_v;
        end
    end

    // Shared grant register: loads when free, holds every field under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_valid_r <= 1'b0;
            grant_chan_r  <= '0;
            grant_id_r    <= '0;
            grant_from_r  <= '0;
            grant_raddr_r <= '0;
            rr_ptr_r      <= '0;
        end else if (free_s) begin
            grant_valid_r <= sel_found_s;
            if (sel_found_s) begin
                grant_chan_r  <= sel_idx_s;
                grant_id_r    <= sel_id_s;
                grant_from_r  <= sel_src_s;
                grant_raddr_r <= grant_slot_addr(sel_src_s);
                rr_ptr_r      <= (sel_idx_s == ChanW'(NumChan - 1)) ? '0 : sel_idx_s + ChanW'(1);
            end else begin
                rr_ptr_r      <= rr_ptr_r;
            end
        end else begin
            grant_valid_r <= grant_valid_r;
        end
    end

    // Per-channel request FSMs with busy flag, finish counter and sticky timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < int'(NumChan); c++) begin
                state_r[c] <= ST_IDLE;
                cnt_r[c]   <= '0;
            end
            busy_r    <= '0;
            timeout_r <= '0;
        end else begin
            for (int c = 0; c < int'(NumChan); c++) begin
                case (state_r[c])
                    ST_IDLE: begin
                        state_r[c] <= act_s[c] ? ST_PENDING : ST_IDLE;
                        busy_r[c]  <= act_s[c];
                    end
                    ST_PENDING: begin
                        if (!act_s[c]) begin
                            state_r[c] <= ST_IDLE;
                            busy_r[c]  <= 1'b0;
                        end else if (load_s && (sel_idx_s == ChanW'(c))) begin
                            state_r[c] <= ST_ISSUED;
                        end else begin
                            state_r[c] <= ST_PENDING;
                        end
                    end
                    ST_ISSUED: begin
                        // At most one channel is ISSUED, so hs_s belongs to it.
                        if (hs_s) begin
                            state_r[c] <= act_s[c] ? ST_WAIT : ST_IDLE;
                            busy_r[c]  <= act_s[c];
                            cnt_r[c]   <= '0;
                        end else begin
                            state_r[c] <= ST_ISSUED;
                        end
                    end
                    ST_WAIT: begin
                        if (!act_s[c]) begin
                            state_r[c] <= ST_IDLE;
                            busy_r[c]  <= 1'b0;
                        end else begin
                            state_r[c] <= ST_WAIT;
                        end
                        if (cnt_r[c] != TMax) begin
                            cnt_r[c] <= cnt_r[c] + CntW'(1);
                        end else begin
                            cnt_r[c] <= cnt_r[c];
                        end
                    end
                    default: begin
                        state_r[c] <= ST_IDLE;
                        busy_r[c]  <= 1'b0;
                    end
                endcase

                if (timeout_clr_i) begin
                    timeout_r[c] <= 1'b0;
                end else if ((TimeoutCycles != 0) && (state_r[c] == ST_WAIT) &&
                             (cnt_r[c] != TMax) && ((cnt_r[c] + CntW'(1)) == TMax)) begin
                    timeout_r[c] <= 1'b1;
                end else begin
                    timeout_r[c] <= timeout_r[c];
                end
            end
        end
    end

    assign grant_valid_o       = grant_valid_r;
    assign grant_chan_o        = grant_chan_r;
    assign grant_id_o          = grant_id_r;
    assign grant_from_o        = grant_from_r;
    assign grant_remote_addr_o = grant_raddr_r;
    assign busy_o              = busy_r;
    assign timeout_o           = timeout_r;

endmodule

// File: tb/tb_xdma_grant_arbiter_mc.sv
// Scoreboard bench for xdma_grant_arbiter_mc: expected grants are queued at stimulus time
// and compared on every observed handshake.
module tb_xdma_grant_arbiter_mc;

    typedef struct packed {
        logic [1:0]  chan;
        logic [7:0]  id;
        logic [47:0] from;
        logic [47:0] raddr;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_rdy = 4'd0;
    logic [3:0]   req_type = 4'd0;
    logic [31:0]  req_id = 32'd0;
    logic [191:0] req_src = 192'd0;
    logic         grant_ready = 1'b0;
    logic         timeout_clr = 1'b0;

    logic         grant_valid;
    logic [1:0]   grant_chan;
    logic [7:0]   grant_id;
    logic [47:0]  grant_from;
    logic [47:0]  grant_raddr;
    logic [3:0]   busy;
    logic [3:0]   timeout;

    logic         nt_valid;
    logic [1:0]   nt_chan;
    logic [7:0]   nt_id;
    logic [47:0]  nt_from;
    logic [47:0]  nt_raddr;
    logic [3:0]   nt_busy;
    logic [3:0]   nt_timeout;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_cyc;

    always #5 clk = ~clk;

    xdma_grant_arbiter_mc #(.NumChan(4), .AddrWidth(48), .IdWidth(8), .TimeoutCycles(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_rdy_i(req_rdy), .req_type_i(req_type),
        .req_id_i(req_id), .req_src_i(req_src), .grant_valid_o(grant_valid),
        .grant_ready_i(grant_ready), .grant_chan_o(grant_chan), .grant_id_o(grant_id),
        .grant_from_o(grant_from), .grant_remote_addr_o(grant_raddr), .busy_o(busy),
        .timeout_o(timeout), .timeout_clr_i(timeout_clr)
    );

    xdma_grant_arbiter_mc #(.NumChan(4), .AddrWidth(48), .IdWidth(8), .TimeoutCycles(0)) dut_nt (
        .clk_i(clk), .rst_ni(rst_n), .req_rdy_i(req_rdy), .req_type_i(req_type),
        .req_id_i(req_id), .req_src_i(req_src), .grant_valid_o(nt_valid),
        .grant_ready_i(grant_ready), .grant_chan_o(nt_chan), .grant_id_o(nt_id),
        .grant_from_o(nt_from), .grant_remote_addr_o(nt_raddr), .busy_o(nt_busy),
        .timeout_o(nt_timeout), .timeout_clr_i(timeout_clr)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input logic a, input logic [7:0] id, input logic [47:0] src);
        req_rdy[c]          = a;
        req_type[c]         = a;
        req_id[c*8 +: 8]    = id;
        req_src[c*48 +: 48] = src;
    endtask

    task automatic push(input logic [1:0] c, input logic [7:0] id, input logic [47:0] src,
                        input logic [47:0] raddr);
        exp_t e;
        e.chan  = c;
        e.id    = id;
        e.from  = src;
        e.raddr = raddr;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int max, output int n);
        n = 0;
        while (sb_q.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check_eq("drain_timeout", 64'(sb_q.size()), 64'd0);
        end
        #1;
    endtask

    task automatic drop_all();
        for (int c = 0; c < 4; c++) begin
            req_rdy[c]  = 1'b0;
            req_type[c] = 1'b0;
        end
        step();
        step();
    endtask

    // Compare every handshake against the oldest expected grant.
    always @(negedge clk) begin
        if (rst_n && grant_valid && grant_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_grant", 64'(grant_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("grant_chan", 64'(grant_chan), 64'(e.chan));
                check_eq("grant_id", 64'(grant_id), 64'(e.id));
                check_eq("grant_from", 64'(grant_from), 64'(e.from));
                check_eq("grant_raddr", 64'(grant_raddr), 64'(e.raddr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_valid", 64'(grant_valid), 64'd0);
        check_eq("rst_chan", 64'(grant_chan), 64'd0);
        check_eq("rst_id", 64'(grant_id), 64'd0);
        check_eq("rst_from", 64'(grant_from), 64'd0);
        check_eq("rst_raddr", 64'(grant_raddr), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_timeout", 64'(timeout), 64'd0);

        // Fairness from rr_ptr = 0
        step();
        grant_ready = 1'b1;
        drive(0, 1'b1, 8'hA0, 48'h0000_0040);
        drive(1, 1'b1, 8'hA1, 48'h0004_0000);
        drive(2, 1'b1, 8'hA2, 48'h0008_0080);
        drive(3, 1'b1, 8'hA3, 48'h000C_0000);
        push(2'd0, 8'hA0, 48'h0000_0040, 48'h0003_FF00);
        push(2'd1, 8'hA1, 48'h0004_0000, 48'h0007_FF00);
        push(2'd2, 8'hA2, 48'h0008_0080, 48'h000B_FF00);
        push(2'd3, 8'hA3, 48'h000C_0000, 48'h000F_FF00);
        wait_drain(20, n_cyc);
        check_eq("fair_cycles", 64'(n_cyc), 64'd6);
        drop_all();
        @(negedge clk);
        check_eq("fair_idle", 64'(busy), 64'd0);
        step();
        drive(0, 1'b1, 8'hB0, 48'h0010_0000);
        drive(2, 1'b1, 8'hB2, 48'h0014_0010);
        push(2'd0, 8'hB0, 48'h0010_0000, 48'h0013_FF00);
        push(2'd2, 8'hB2, 48'h0014_0010, 48'h0017_FF00);
        wait_drain(20, n_cyc);
        check_eq("fair2_cycles", 64'(n_cyc), 64'd4);
        drop_all();

        // Single grant after a fresh reset: latency and WAIT_FINISH exit
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        grant_ready = 1'b1;
        drive(0, 1'b1, 8'h12, 48'h1004_0010);
        push(2'd0, 8'h12, 48'h1004_0010, 48'h1007_FF00);
        @(negedge clk);
        check_eq("lat_cyc0", 64'(grant_valid), 64'd0);
        step();
        @(negedge clk);
        check_eq("lat_cyc1", 64'(grant_valid), 64'd0);
        step();
        @(negedge clk);
        check_eq("lat_cyc2", 64'(grant_valid), 64'd1);
        step();
        @(negedge clk);
        check_eq("single_wait_busy", 64'(busy), 64'd1);
        step();
        drive(0, 1'b0, 8'h12, 48'h1004_0010);
        step();
        @(negedge clk);
        check_eq("single_idle", 64'(busy), 64'd0);

        // Backpressure with a late requester and a cancelled one
        step();
        grant_ready = 1'b0;
        drive(0, 1'b1, 8'h34, 48'h2000_0100);
        push(2'd0, 8'h34, 48'h2000_0100, 48'h2003_FF00);
        push(2'd1, 8'h56, 48'h3000_0000, 48'h3003_FF00);
        step();
        step();
        drive(1, 1'b1, 8'h56, 48'h3000_0000);
        drive(3, 1'b1, 8'h99, 48'h0000_0005);
        @(negedge clk);
        check_eq("bp_valid_up", 64'(grant_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) drive(3, 1'b0, 8'h99, 48'h0000_0005);
            @(negedge clk);
            check_eq("bp_valid", 64'(grant_valid), 64'd1);
            check_eq("bp_chan", 64'(grant_chan), 64'd0);
            check_eq("bp_id", 64'(grant_id), 64'h34);
            check_eq("bp_raddr", 64'(grant_raddr), 64'h2003_FF00);
            if (i == 0) check_eq("cancel_busy_set", 64'(busy[3]), 64'd1);
            if (i == 1) check_eq("cancel_busy_clr", 64'(busy[3]), 64'd0);
            if (i == 1) check_eq("bp_ch1_pending", 64'(busy[1]), 64'd1);
        end
        step();
        grant_ready = 1'b1;
        wait_drain(10, n_cyc);
        check_eq("bp_release_cycles", 64'(n_cyc), 64'd2);
        drop_all();

        // dma_type = 0 never needs a grant
        req_rdy[2] = 1'b1;
        step();
        step();
        @(negedge clk);
        check_eq("type0_busy", 64'(busy[2]), 64'd0);
        step();
        req_rdy[2] = 1'b0;

        // Main-memory boundary addresses, round robin resuming at ch2
        drive(1, 1'b1, 8'h71, 48'h8000_0000);
        drive(2, 1'b1, 8'h78, 48'h9000_0000);
        drive(3, 1'b1, 8'h73, 48'h7FFF_FFF0);
        push(2'd2, 8'h78, 48'h9000_0000, 48'hFFFF_FF00);
        push(2'd3, 8'h73, 48'h7FFF_FFF0, 48'h7FFF_FF00);
        push(2'd1, 8'h71, 48'h8000_0000, 48'hFFFF_FF00);
        wait_drain(20, n_cyc);
        check_eq("mm_cycles", 64'(n_cyc), 64'd5);
        drop_all();

        // Finish timeout
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        @(negedge clk);
        check_eq("to_cleared_pre", 64'(timeout), 64'd0);
        step();
        drive(1, 1'b1, 8'h11, 48'h0000_0040);
        push(2'd1, 8'h11, 48'h0000_0040, 48'h0003_FF00);
        wait_drain(10, n_cyc);
        repeat (7) step();
        @(negedge clk);
        check_eq("to_not_yet", 64'(timeout[1]), 64'd0);
        step();
        @(negedge clk);
        check_eq("to_set", 64'(timeout), 64'b0010);
        check_eq("to_disabled", 64'(nt_timeout), 64'd0);
        drop_all();
        @(negedge clk);
        check_eq("to_sticky", 64'(timeout[1]), 64'd1);
        check_eq("to_sticky_idle", 64'(busy[1]), 64'd0);
        step();
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        @(negedge clk);
        check_eq("to_clr", 64'(timeout), 64'd0);

        // Reset during a blocked handshake
        step();
        grant_ready = 1'b0;
        drive(0, 1'b1, 8'h5A, 48'h0001_0000);
        step();
        step();
        @(negedge clk);
        check_eq("rh_valid", 64'(grant_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rh_async_valid", 64'(grant_valid), 64'd0);
        check_eq("rh_async_id", 64'(grant_id), 64'd0);
        check_eq("rh_async_from", 64'(grant_from), 64'd0);
        check_eq("rh_async_raddr", 64'(grant_raddr), 64'd0);
        check_eq("rh_async_busy", 64'(busy), 64'd0);
        sb_q.delete();
        step();
        step();
        push(2'd0, 8'h5A, 48'h0001_0000, 48'h0003_FF00);
        grant_ready = 1'b1;
        rst_n = 1'b1;
        wait_drain(10, n_cyc);
        check_eq("rh_fresh_cycles", 64'(n_cyc), 64'd3);
        drop_all();

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
